// File: rtl/fpga_mbox_arb_pkg.sv
// Shared types and default widths for the FPGA mailbox SRAM arbiter.
package fpga_mbox_arb_pkg;

    localparam int unsigned MBOX_ADDR_W = 15;
    localparam int unsigned MBOX_DATA_W = 39;
    localparam int unsigned NUM_REQ     = 2;
    localparam int unsigned REQ_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // One backdoor access as presented to the SRAM
    typedef struct packed {
        logic                   we;
        logic [MBOX_ADDR_W-1:0] addr;
        logic [MBOX_DATA_W-1:0] wdata;
    } bd_req_t;

endpackage

// File: rtl/fpga_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
module fpga_rr_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    id_c
);

    // Scan from rr_ptr with wraparound; rr_ptr is always < NUM_REQ
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_c = '0;
        id_c    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !found && valid[ID_W'(idx)]) begin
                grant_c[ID_W'(idx)] = 1'b1;
                id_c                = ID_W'(idx);
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpga_mbox_sram_arb.sv
// Shares the FPGA mailbox SRAM between Caliptra (absolute priority) and
// round-robin backdoor requesters, with starvation monitoring.
module fpga_mbox_sram_arb
    import fpga_mbox_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = fpga_mbox_arb_pkg::MBOX_ADDR_W,
    parameter int unsigned DATA_W     = fpga_mbox_arb_pkg::MBOX_DATA_W,
    parameter int unsigned NUM_REQ    = fpga_mbox_arb_pkg::NUM_REQ,
    parameter int unsigned STARVE_LIM = 255,
    localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      core_clk,
    input  logic                      cptra_rst_b,
    input  logic                      cptra_sram_cs,
    input  logic                      cptra_sram_we,
    input  logic [ADDR_W-1:0]         cptra_sram_addr,
    input  logic [DATA_W-1:0]         cptra_sram_wdata,
    output logic [DATA_W-1:0]         cptra_sram_rdata,
    input  logic                      bd_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [NUM_REQ-1:0]        starve,
    input  logic                      starve_clr,
    output logic                      sram_cs,
    output logic                      sram_we,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata
);

    localparam int unsigned LIM_W = $clog2(STARVE_LIM + 1);
    localparam int unsigned CNT_W = (LIM_W > 8) ? LIM_W : 8;

    logic                 bd_active_c;
    logic [NUM_REQ-1:0]   grant_c;
    logic [ID_W-1:0]      grant_id_c;
    logic                 bd_xfer_c;
    bd_req_t              sel_req_c;
    logic [ID_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]     wait_cnt     [NUM_REQ];
    logic [CNT_W-1:0]     wait_cnt_inc [NUM_REQ];

    // Backdoor only sees idle SRAM cycles
    assign bd_active_c = !cptra_sram_cs && bd_en;

    fpga_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .valid   (req_valid),
        .rr_ptr  (rr_ptr),
        .en      (bd_active_c),
        .grant_c (grant_c),
        .id_c    (grant_id_c)
    );

    assign req_ready = grant_c;
    assign bd_xfer_c = |grant_c;

    // Select the granted requester's payload
    always_comb begin
        sel_req_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_req_c.we    = req_we[i];
                sel_req_c.addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_req_c.wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // SRAM port mux: Caliptra first, then granted backdoor, else quiet zeros
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (cptra_sram_cs) begin
            sram_cs    = 1'b1;
            sram_we    = cptra_sram_we;
            sram_addr  = cptra_sram_addr;
            sram_wdata = cptra_sram_wdata;
        end else if (bd_xfer_c) begin
            sram_cs    = 1'b1;
            sram_we    = sel_req_c.we;
            sram_addr  = sel_req_c.addr;
            sram_wdata = sel_req_c.wdata;
        end
    end

    assign cptra_sram_rdata = sram_rdata;
    assign rsp_rdata        = sram_rdata;

    // Round-robin pointer moves just past the requester that transferred
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            rr_ptr <= '0;
        end else if (bd_xfer_c) begin
            rr_ptr <= (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
        end
    end

    // Read response one cycle after a backdoor read transfer
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= bd_xfer_c && !sel_req_c.we;
            if (bd_xfer_c && !sel_req_c.we) begin
                rsp_id <= grant_id_c;
            end
        end
    end

    // Saturating increment of each wait counter
    always_comb begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            wait_cnt_inc[k] = (wait_cnt[k] == '1) ? wait_cnt[k] : wait_cnt[k] + CNT_W'(1);
        end
    end

    // Wait counters and sticky starve flags; starve_clr overrides everything
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                wait_cnt[k] <= '0;
            end
            starve <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (starve_clr) begin
                    wait_cnt[k] <= '0;
                    starve[k]   <= 1'b0;
                end else if (!req_valid[k] || req_ready[k]) begin
                    wait_cnt[k] <= '0;
                end else begin
                    wait_cnt[k] <= wait_cnt_inc[k];
                    if (wait_cnt_inc[k] >= CNT_W'(STARVE_LIM)) begin
                        starve[k] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
